// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the AHB register interface and the USB RX/TX packet
// engines. One storage array and one occupancy count serve both directions.
// The head byte is shown combinationally on both read ports (zero-latency show-ahead).
//
// Optional feature: define DATA_BUFFER_ERR_EN to add the sticky buffer_error
// output. It flags a push while full (with no pop) or a pop while empty (with no push).
module usb_data_buffer #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             store_tx_data,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             store_rx_packet_data,
   input  logic [WIDTH-1:0] rx_packet_data,
   input  logic             get_rx_data,
   input  logic             get_tx_packet_data,
   output logic [WIDTH-1:0] rx_data,
   output logic [WIDTH-1:0] tx_packet_data,
   output logic [AW:0]      buffer_occupancy
`ifdef DATA_BUFFER_ERR_EN
   ,
   output logic             buffer_error
`endif
);

   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];

   // Pointers carry one extra wrap bit above the index
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             empty, full;
   logic             push, pop;
   logic             do_push, do_pop;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] head;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   assign push = store_rx_packet_data | store_tx_data;
   assign pop  = get_rx_data | get_tx_packet_data;

   // A full buffer still accepts a push when the same cycle frees a slot
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   // RX engine wins when both sources push together
   assign wdata = store_rx_packet_data ? rx_packet_data : tx_data;

   assign head           = empty ? '0 : mem[rptr_q[AW-1:0]];
   assign rx_data        = head;
   assign tx_packet_data = head;

   // Next-state pointers; clear overrides any push or pop
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clear) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrOne;
         if (do_pop)  rptr_d = rptr_q + PtrOne;
      end
   end

   // Pointer and registered occupancy state
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr_q           <= '0;
         rptr_q           <= '0;
         buffer_occupancy <= '0;
      end else begin
         wptr_q           <= wptr_d;
         rptr_q           <= rptr_d;
         buffer_occupancy <= wptr_d - rptr_d;
      end
   end

   // Storage array; contents need no reset
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wptr_q[AW-1:0]] <= wdata;
      end
   end

`ifdef DATA_BUFFER_ERR_EN
   // Sticky overflow/underflow flag, dropped only by clear or reset
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         buffer_error <= 1'b0;
      end else if (clear) begin
         buffer_error <= 1'b0;
      end else if ((push && full && !pop) || (pop && empty && !push)) begin
         buffer_error <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: scoreboard queue of expected head bytes.
module tb_usb_data_buffer;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             n_rst;
   logic             clear;
   logic             store_tx_data;
   logic [WIDTH-1:0] tx_data;
   logic             store_rx_packet_data;
   logic [WIDTH-1:0] rx_packet_data;
   logic             get_rx_data;
   logic             get_tx_packet_data;
   logic [WIDTH-1:0] rx_data;
   logic [WIDTH-1:0] tx_packet_data;
   logic [AW:0]      buffer_occupancy;
`ifdef DATA_BUFFER_ERR_EN
   logic             buffer_error;
`endif

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] sb [$];

   usb_data_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .clear                (clear),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_rx_data          (get_rx_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .rx_data              (rx_data),
      .tx_packet_data       (tx_packet_data),
      .buffer_occupancy     (buffer_occupancy)
`ifdef DATA_BUFFER_ERR_EN
      ,
      .buffer_error         (buffer_error)
`endif
   );

   always #5 clk = ~clk;

   // One clock edge, then settle 1 ns so outputs are sampled away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear = 1'b0;
      store_tx_data = 1'b0;
      tx_data = '0;
      store_rx_packet_data = 1'b0;
      rx_packet_data = '0;
      get_rx_data = 1'b0;
      get_tx_packet_data = 1'b0;
   endtask

   task automatic check_occ(input string name, input int exp);
      checks++;
      if (buffer_occupancy !== exp[AW:0]) begin
         errors++;
         $display("FAIL %s occupancy got %0d want %0d", name, buffer_occupancy, exp);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      n_rst = 1'b0;
      step();
      step();
      check_occ("reset", 0);
      checks++;
      if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %h/%h want 00/00", rx_data, tx_packet_data);
      end
`ifdef DATA_BUFFER_ERR_EN
      checks++;
      if (buffer_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b want 0", buffer_error);
      end
`endif
      n_rst = 1'b1;
      step();
   endtask

   task automatic test_tx_path();
      logic [WIDTH-1:0] bytes [2];
      logic [WIDTH-1:0] exp;
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         store_tx_data = 1'b1;
         tx_data = bytes[i];
         sb.push_back(bytes[i]);
         step();
      end
      idle_inputs();
      check_occ("tx_fill", 2);
      for (int i = 0; i < 2; i++) begin
         exp = sb.pop_front();
         checks++;
         if (tx_packet_data !== exp) begin
            errors++;
            $display("FAIL tx_pop%0d got %h want %h", i, tx_packet_data, exp);
         end
         get_tx_packet_data = 1'b1;
         step();
         idle_inputs();
         check_occ("tx_drain", 1 - i);
      end
      checks++;
      if (tx_packet_data !== 8'h00) begin
         errors++;
         $display("FAIL tx_empty_head got %h want 00", tx_packet_data);
      end
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] exp;
      for (int i = 0; i < DEPTH; i++) begin
         store_rx_packet_data = 1'b1;
         rx_packet_data = i[WIDTH-1:0];
         sb.push_back(i[WIDTH-1:0]);
         step();
      end
      idle_inputs();
      check_occ("full", DEPTH);
      // Push while full is dropped
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'hFF;
      step();
      idle_inputs();
      check_occ("full_drop", DEPTH);
      // Push and pop together while full: both taken
      exp = sb.pop_front();
      checks++;
      if (rx_data !== exp) begin
         errors++;
         $display("FAIL full_pushpop_head got %h want %h", rx_data, exp);
      end
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'h40;
      get_rx_data = 1'b1;
      sb.push_back(8'h40);
      step();
      idle_inputs();
      check_occ("full_pushpop", DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         exp = sb.pop_front();
         checks++;
         if (rx_data !== exp || tx_packet_data !== exp) begin
            errors++;
            $display("FAIL ahb_pop%0d got %h/%h want %h", i, rx_data, tx_packet_data, exp);
         end
         get_rx_data = 1'b1;
         step();
         idle_inputs();
      end
      check_occ("ahb_drained", 0);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 10; i++) begin
         store_tx_data = 1'b1;
         tx_data = 8'h80 + i[WIDTH-1:0];
         step();
      end
      idle_inputs();
      check_occ("pre_clear", 10);
      clear = 1'b1;
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'h77;
      step();
      idle_inputs();
      check_occ("clear", 0);
      checks++;
      if (rx_data !== 8'h00) begin
         errors++;
         $display("FAIL clear_head got %h want 00", rx_data);
      end
`ifdef DATA_BUFFER_ERR_EN
      checks++;
      if (buffer_error !== 1'b0) begin
         errors++;
         $display("FAIL clear_err got %b want 0", buffer_error);
      end
`endif
   endtask

   task automatic test_dual_push();
      logic [WIDTH-1:0] exp;
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'h11;
      store_tx_data = 1'b1;
      tx_data = 8'h22;
      sb.push_back(8'h11);
      step();
      idle_inputs();
      check_occ("dual_push", 1);
      exp = sb.pop_front();
      checks++;
      if (rx_data !== exp) begin
         errors++;
         $display("FAIL dual_push_head got %h want %h", rx_data, exp);
      end
      get_rx_data = 1'b1;
      step();
      idle_inputs();
      check_occ("dual_pop", 0);
      // Pop on empty is ignored
      get_rx_data = 1'b1;
      get_tx_packet_data = 1'b1;
      step();
      idle_inputs();
      check_occ("empty_pop", 0);
`ifdef DATA_BUFFER_ERR_EN
      checks++;
      if (buffer_error !== 1'b1) begin
         errors++;
         $display("FAIL underflow_err got %b want 1", buffer_error);
      end
      clear = 1'b1;
      step();
      idle_inputs();
`endif
      // Empty + push + pop: push taken, pop ignored
      store_tx_data = 1'b1;
      tx_data = 8'h5A;
      get_rx_data = 1'b1;
      sb.push_back(8'h5A);
      step();
      idle_inputs();
      check_occ("empty_pushpop", 1);
      exp = sb.pop_front();
      checks++;
      if (tx_packet_data !== exp) begin
         errors++;
         $display("FAIL empty_pushpop_head got %h want %h", tx_packet_data, exp);
      end
      get_tx_packet_data = 1'b1;
      step();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] exp;
      logic [WIDTH-1:0] nb;
      for (int i = 0; i < 3; i++) begin
         nb = $urandom_range(0, 255);
         store_rx_packet_data = 1'b1;
         rx_packet_data = nb;
         sb.push_back(nb);
         step();
      end
      idle_inputs();
      check_occ("b2b_prime", 3);
      for (int i = 0; i < 200; i++) begin
         exp = sb.pop_front();
         checks++;
         if (rx_data !== exp) begin
            errors++;
            $display("FAIL b2b_head%0d got %h want %h", i, rx_data, exp);
         end
         nb = $urandom_range(0, 255);
         store_rx_packet_data = 1'b1;
         rx_packet_data = nb;
         get_tx_packet_data = 1'b1;
         sb.push_back(nb);
         step();
         idle_inputs();
         check_occ("b2b_level", 3);
      end
      for (int i = 0; i < 3; i++) begin
         exp = sb.pop_front();
         checks++;
         if (tx_packet_data !== exp) begin
            errors++;
            $display("FAIL b2b_drain%0d got %h want %h", i, tx_packet_data, exp);
         end
         get_tx_packet_data = 1'b1;
         step();
         idle_inputs();
      end
      check_occ("b2b_empty", 0);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         store_tx_data = 1'b1;
         tx_data = 8'hC0 + i[WIDTH-1:0];
         step();
      end
      idle_inputs();
      check_occ("pre_async", 5);
      // Assert reset mid-cycle, well away from any clock edge
      #2;
      n_rst = 1'b0;
      #1;
      check_occ("async_reset", 0);
      checks++;
      if (rx_data !== 8'h00) begin
         errors++;
         $display("FAIL async_reset_head got %h want 00", rx_data);
      end
      step();
      n_rst = 1'b1;
      step();
      sb.delete();
   endtask

   initial begin
      idle_inputs();
      n_rst = 1'b1;
      #3;
      test_reset();
      test_tx_path();
      test_overflow();
      test_clear();
      test_dual_push();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
